// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            i_flush;
  logic [5:0]      i_opcode;
  logic [5:0]      i_func_code;
  logic [XLEN-1:0] i_rs_data;
  logic [XLEN-1:0] i_rt_data;
  logic            o_busy;
  logic            o_stall;
  logic [XLEN-1:0] o_mf_data;
  logic [XLEN-1:0] o_hi;
  logic [XLEN-1:0] o_lo;

  modport master (
    output i_valid, i_flush, i_opcode, i_func_code, i_rs_data, i_rt_data,
    input  o_busy, o_stall, o_mf_data, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_flush, i_opcode, i_func_code, i_rs_data, i_rt_data,
    output o_busy, o_stall, o_mf_data, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; shift-add multiply, restoring divide.
// Optional MADD/MADDU accumulate is enabled by defining MULDIV_MADD_EN.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
`ifdef MULDIV_MADD_EN
  localparam logic [5:0] OP_MADD    = 6'h1C;
  localparam logic [5:0] FN_MADD    = 6'h00;
  localparam logic [5:0] FN_MADDU   = 6'h01;
`endif
  localparam int unsigned CW = $clog2(ITER);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              div_q, div_d, negq_q, negq_d, negr_q, negr_d;
`ifdef MULDIV_MADD_EN
  logic              madd_q, madd_d;
`endif

  logic              special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mul, is_div, is_madd;
  logic              sgn, rs_neg, rt_neg, busy, stall, take;
  logic [XLEN-1:0]   rs_mag, rt_mag, mf_data;
  logic [XLEN:0]     mul_sum, div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    special = bus.i_opcode == OP_SPECIAL;
    is_mfhi = special && bus.i_func_code == FN_MFHI;
    is_mflo = special && bus.i_func_code == FN_MFLO;
    is_mthi = special && bus.i_func_code == FN_MTHI;
    is_mtlo = special && bus.i_func_code == FN_MTLO;
    is_mul  = special && (bus.i_func_code == FN_MULT || bus.i_func_code == FN_MULTU);
    is_div  = special && (bus.i_func_code == FN_DIV || bus.i_func_code == FN_DIVU);
`ifdef MULDIV_MADD_EN
    is_madd = bus.i_opcode == OP_MADD &&
              (bus.i_func_code == FN_MADD || bus.i_func_code == FN_MADDU);
`else
    is_madd = 1'b0;
`endif
    // Every supported encoding uses an even function code for the signed form.
    sgn    = ~bus.i_func_code[0];
    rs_neg = sgn & bus.i_rs_data[XLEN-1];
    rt_neg = sgn & bus.i_rt_data[XLEN-1];
    rs_mag = rs_neg ? -bus.i_rs_data : bus.i_rs_data;
    rt_mag = rt_neg ? -bus.i_rt_data : bus.i_rt_data;

    busy  = state_q != S_IDLE;
    stall = bus.i_valid && !bus.i_flush && busy &&
            (is_mfhi || is_mflo || is_mthi || is_mtlo || is_mul || is_div || is_madd);
    take  = bus.i_valid && !bus.i_flush && !stall;

    mf_data = '0;
    if (is_mfhi)      mf_data = hi_q;
    else if (is_mflo) mf_data = lo_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`ifdef MULDIV_MADD_EN
    madd_d  = madd_q;
`endif
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    prod     = negq_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (take && (is_mul || is_madd)) begin
          acc_d   = {{XLEN{1'b0}}, rt_mag};
          opnd_d  = rs_mag;
          negq_d  = rs_neg ^ rt_neg;
          negr_d  = 1'b0;
          div_d   = 1'b0;
          count_d = '0;
          state_d = S_RUN;
`ifdef MULDIV_MADD_EN
          madd_d  = is_madd;
`endif
        end else if (take && is_div) begin
          div_d   = 1'b1;
          count_d = '0;
`ifdef MULDIV_MADD_EN
          madd_d  = 1'b0;
`endif
          // Divide-by-zero result is preloaded so FIXUP writes it unmodified.
          if (bus.i_rt_data == '0) begin
            acc_d   = {bus.i_rs_data, {XLEN{1'b1}}};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_FIXUP;
          end else begin
            acc_d   = {{XLEN{1'b0}}, rs_mag};
            opnd_d  = rt_mag;
            negq_d  = rs_neg ^ rt_neg;
            negr_d  = rs_neg;
            state_d = S_RUN;
          end
        end else if (take && is_mthi) begin
          hi_d = bus.i_rs_data;
        end else if (take && is_mtlo) begin
          lo_d = bus.i_rs_data;
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        if (div_q) begin
          if (!div_diff[XLEN+1])
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (count_q == CW'(ITER - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (div_q) begin
          lo_d = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
`ifdef MULDIV_MADD_EN
          if (madd_q) {hi_d, lo_d} = {hi_q, lo_q} + prod;
          else        {hi_d, lo_d} = prod;
`else
          {hi_d, lo_d} = prod;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`ifdef MULDIV_MADD_EN
      madd_q  <= madd_d;
`endif
    end
  end

  assign bus.o_busy    = busy;
  assign bus.o_stall   = stall;
  assign bus.o_mf_data = mf_data;
  assign bus.o_hi      = hi_q;
  assign bus.o_lo      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: latency-level HI/LO model plus directed literal checks.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op simply retires 33 cycles later (1 for divide-by-zero).
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_rem = 0;
  logic [63:0] m_pend = '0;
  bit          m_acc = 1'b0;

  function automatic bit is_madd(input logic [5:0] op, input logic [5:0] fn);
`ifdef MULDIV_MADD_EN
    return op == 6'h1C && (fn == 6'h00 || fn == 6'h01);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit uses_unit(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00 && (fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}))
           || is_madd(op, fn);
  endfunction

  // kind: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; returns {HI,LO}
  function automatic logic [63:0] calc(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    longint sa, sb, q, r;
    logic [63:0] qv, rv, res;
    sa = longint'(signed'(rs));
    sb = longint'(signed'(rt));
    res = '0;
    case (kind)
      0: res = sa * sb;
      1: res = {32'b0, rs} * {32'b0, rt};
      2: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          res = {rv[31:0], qv[31:0]};
        end
      end
      default: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else res = {rs % rt, rs / rt};
      end
    endcase
    return res;
  endfunction

  bit m_stall, m_take;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_acc = 1'b0;
    end else begin
      m_stall = bus.i_valid && !bus.i_flush && m_rem > 0 && uses_unit(bus.i_opcode, bus.i_func_code);
      m_take  = bus.i_valid && !bus.i_flush && !m_stall;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_acc) {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
          else       {m_hi, m_lo} = m_pend;
        end
      end else if (m_take && bus.i_opcode == 6'h00) begin
        case (bus.i_func_code)
          6'h11: m_hi = bus.i_rs_data;
          6'h13: m_lo = bus.i_rs_data;
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            m_pend = calc(int'(bus.i_func_code[1:0]), bus.i_rs_data, bus.i_rt_data);
            m_acc  = 1'b0;
            m_rem  = (bus.i_func_code[1] && bus.i_rt_data == 32'd0) ? 1 : 33;
          end
          default: ;
        endcase
      end else if (m_take && is_madd(bus.i_opcode, bus.i_func_code)) begin
        m_pend = calc(int'(bus.i_func_code[0]), bus.i_rs_data, bus.i_rt_data);
        m_acc  = 1'b1;
        m_rem  = 33;
      end
    end
  end

  bit e_busy, e_stall, is_mf;
  always @(negedge clk) begin
    if (rst_n) begin
      e_busy  = m_rem > 0;
      e_stall = bus.i_valid && !bus.i_flush && e_busy && uses_unit(bus.i_opcode, bus.i_func_code);
      is_mf   = bus.i_opcode == 6'h00 && (bus.i_func_code == 6'h10 || bus.i_func_code == 6'h12);
      chk("busy", 64'(bus.o_busy), 64'(e_busy));
      chk("stall", 64'(bus.o_stall), 64'(e_stall));
      chk("hi", 64'(bus.o_hi), 64'(m_hi));
      chk("lo", 64'(bus.o_lo), 64'(m_lo));
      if (!is_mf) chk("mf_zero", 64'(bus.o_mf_data), 64'h0);
      else if (bus.i_valid && !e_stall)
        chk("mf_data", 64'(bus.o_mf_data), 64'(bus.i_func_code == 6'h10 ? m_hi : m_lo));
    end
  end

  task automatic drive(input logic v, input logic f, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    bus.i_valid = v; bus.i_flush = f; bus.i_opcode = op;
    bus.i_func_code = fn; bus.i_rs_data = rs; bus.i_rt_data = rt;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    drive(1'b1, 1'b0, op, fn, rs, rt);
    idle(34);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(15));
      5: return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  int n_stall;
  bit served;
  logic [5:0] r_op, r_fn;
  initial begin
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_opcode = '0;
    bus.i_func_code = '0; bus.i_rs_data = '0; bus.i_rt_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(bus.o_busy), 64'h0);
    chk("reset_hilo", {bus.o_hi, bus.o_lo}, 64'h0);

    drive(1'b1, 1'b0, 6'h00, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);  @(negedge clk); chk("multu_busy_n1", 64'(bus.o_busy), 64'h1);
    idle(32); @(negedge clk); chk("multu_busy_n33", 64'(bus.o_busy), 64'h1);
    idle(1);  @(negedge clk); chk("multu_busy_n34", 64'(bus.o_busy), 64'h0);
    chk("multu_hilo", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(6'h00, 6'h18, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(6'h00, 6'h1A, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {bus.o_hi, bus.o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    drive(1'b1, 1'b0, 6'h00, 6'h1B, 32'd100, 32'd7);
    idle(4);
    n_stall = 0; served = 1'b0;
    for (int i = 0; i < 40 && !served; i++) begin
      drive(1'b1, 1'b0, 6'h00, 6'h12, 32'h0, 32'h0);
      @(negedge clk);
      if (!bus.o_stall) served = 1'b1;
      else n_stall++;
    end
    chk("mflo_served", 64'(served), 64'h1);
    chk("mflo_stall_cycles", 64'(n_stall), 64'd29);
    chk("mflo_data", 64'(bus.o_mf_data), 64'd14);
    drive(1'b1, 1'b0, 6'h00, 6'h10, 32'h0, 32'h0);
    @(negedge clk); chk("mfhi_data", 64'(bus.o_mf_data), 64'd2);

    drive(1'b1, 1'b0, 6'h00, 6'h1B, 32'h1234, 32'h0);
    idle(1); @(negedge clk); chk("dz_busy_n1", 64'(bus.o_busy), 64'h1);
    idle(1); @(negedge clk); chk("dz_busy_n2", 64'(bus.o_busy), 64'h0);
    chk("dz_hilo", {bus.o_hi, bus.o_lo}, 64'h0000_1234_FFFF_FFFF);

    run_op(6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {bus.o_hi, bus.o_lo}, 64'h0000_0000_8000_0000);

    drive(1'b1, 1'b1, 6'h00, 6'h11, 32'hAAAA_0000, 32'h0);
    idle(1); @(negedge clk); chk("mthi_flushed", 64'(bus.o_hi), 64'h0);
    drive(1'b1, 1'b0, 6'h00, 6'h11, 32'hAAAA_0000, 32'h0);
    idle(1); @(negedge clk); chk("mthi", 64'(bus.o_hi), 64'hAAAA_0000);
    drive(1'b1, 1'b1, 6'h00, 6'h18, 32'd3, 32'd4);
    idle(1); @(negedge clk); chk("mult_flushed_busy", 64'(bus.o_busy), 64'h0);

    drive(1'b1, 1'b0, 6'h00, 6'h18, 32'd7, 32'd9);
    idle(9);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(bus.o_busy), 64'h0);
    chk("rst_mid_hilo", {bus.o_hi, bus.o_lo}, 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

`ifdef MULDIV_MADD_EN
    drive(1'b1, 1'b0, 6'h00, 6'h13, 32'd5, 32'h0);
    drive(1'b1, 1'b0, 6'h00, 6'h11, 32'd0, 32'h0);
    run_op(6'h1C, 6'h00, 32'd3, 32'd4);
    chk("madd", {bus.o_hi, bus.o_lo}, 64'd17);
`endif

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(11))
        0: begin r_op = 6'h00; r_fn = 6'h10; end
        1: begin r_op = 6'h00; r_fn = 6'h11; end
        2: begin r_op = 6'h00; r_fn = 6'h12; end
        3: begin r_op = 6'h00; r_fn = 6'h13; end
        4: begin r_op = 6'h00; r_fn = 6'h18; end
        5: begin r_op = 6'h00; r_fn = 6'h19; end
        6: begin r_op = 6'h00; r_fn = 6'h1A; end
        7: begin r_op = 6'h00; r_fn = 6'h1B; end
        8: begin r_op = 6'h1C; r_fn = 6'h00; end
        9: begin r_op = 6'h1C; r_fn = 6'h01; end
        default: begin r_op = 6'($urandom); r_fn = 6'($urandom); end
      endcase
      drive($urandom_range(3) != 0, $urandom_range(7) == 0, r_op, r_fn, rnd_opnd(), rnd_opnd());
    end
    idle(40);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
